conv3x3: RTL

CONV3X3 -- requirements
Module: conv3x3

---
 rtl/img_pkg.sv | 35 +++
 rtl/conv3x3_if.sv | 25 ++
 rtl/conv3x3_row.sv | 35 +++
 rtl/conv3x3.sv | 122 ++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-processing types and constants for the 3x3 convolution slice.
package img_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned COEF_W      = 8;
  localparam int unsigned KERNEL_TAPS = 9;
  localparam int unsigned ACC_W       = 21;

  typedef logic        [DATA_W-1:0] pixel_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  typedef pixel_t [KERNEL_TAPS-1:0] window_t;
  typedef coef_t  [KERNEL_TAPS-1:0] kernel_t;

  typedef struct packed {
    kernel_t    coef;
    logic [3:0] shift;
  } bank_t;

  // Pass-through kernel: centre tap 1, everything else 0, no shift.
  function automatic kernel_t identity_kernel();
    kernel_t k;
    k = '0;
    k[KERNEL_TAPS/2] = coef_t'(1);
    return k;
  endfunction

  function automatic bank_t identity_bank();
    bank_t b;
    b.coef  = identity_kernel();
    b.shift = '0;
    return b;
  endfunction

endpackage

// File: rtl/conv3x3_if.sv
// Window/coefficient/result bundle between a line buffer and conv3x3.
interface conv3x3_if;
  import img_pkg::*;

  logic       i_valid;
  window_t    i_data;
  logic       i_coef_wr;
  coef_t      i_coef;
  logic [3:0] i_shift;

  logic       o_valid;
  pixel_t     o_data;
  logic       o_coef_ready;

  modport master (
    output i_valid, i_data, i_coef_wr, i_coef, i_shift,
    input  o_valid, o_data, o_coef_ready
  );

  modport slave (
    input  i_valid, i_data, i_coef_wr, i_coef, i_shift,
    output o_valid, o_data, o_coef_ready
  );

endinterface

// File: rtl/conv3x3_row.sv
// One kernel row: three tap products registered (S1), then their row sum (S2).
module conv3x3_row
  import img_pkg::*;
#(
  parameter int unsigned PROD_W = 17,
  parameter int unsigned SUM_W  = 19
) (
  input  logic                    clk,
  input  pixel_t [2:0]            taps_i,
  input  coef_t  [2:0]            coefs_i,
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [PROD_W-1:0] prod_d [3];
  logic signed [PROD_W-1:0] prod_q [3];
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  sum_q;

  // Taps are unsigned: zero-extend by one bit so the signed multiply sees them positive.
  always_comb begin
    prod_d = '{default: '0};
    for (int unsigned k = 0; k < 3; k++) begin
      prod_d[k] = PROD_W'($signed({1'b0, taps_i[k]})) * PROD_W'($signed(coefs_i[k]));
    end
    sum_d = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]);
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    sum_q  <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/conv3x3.sv
// 3x3 signed-kernel convolution, 4-stage pipeline with double-buffered kernel.
// Define CONV3X3_ROUND_EN to round-half-up before the shift instead of truncating.
module conv3x3
  import img_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8
) (
  input  logic     i_clk,
  input  logic     i_rst,
  conv3x3_if.slave bus
);

  localparam int unsigned PROD_W   = DATA_W + 1 + COEF_W;
  localparam int unsigned ROW_W    = PROD_W + 2;
  localparam logic [3:0]  LAST_IDX = 4'(KERNEL_TAPS - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

  logic [3:0] idx_q, idx_d;
  kernel_t    shadow_q, shadow_d;
  bank_t      active_q, active_d;

  logic       v1_q, v2_q, v3_q, v4_q;
  logic [3:0] shift_s1_q, shift_s2_q;

  logic signed [ROW_W-1:0] row_sum [3];
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] total_d, total_q;
  pixel_t                  out_d, out_q;

  // Ninth write commits the shadow bank (including this last coefficient) atomically.
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (bus.i_coef_wr) begin
      shadow_d[idx_q] = bus.i_coef;
      if (idx_q == LAST_IDX) begin
        idx_d          = '0;
        active_d.coef  = shadow_d;
        active_d.shift = bus.i_shift;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  conv3x3_row #(.PROD_W(PROD_W), .SUM_W(ROW_W)) u_row0 (
    .clk     (i_clk),
    .taps_i  (bus.i_data[2:0]),
    .coefs_i (active_q.coef[2:0]),
    .sum_o   (row_sum[0])
  );

  conv3x3_row #(.PROD_W(PROD_W), .SUM_W(ROW_W)) u_row1 (
    .clk     (i_clk),
    .taps_i  (bus.i_data[5:3]),
    .coefs_i (active_q.coef[5:3]),
    .sum_o   (row_sum[1])
  );

  conv3x3_row #(.PROD_W(PROD_W), .SUM_W(ROW_W)) u_row2 (
    .clk     (i_clk),
    .taps_i  (bus.i_data[8:6]),
    .coefs_i (active_q.coef[8:6]),
    .sum_o   (row_sum[2])
  );

  // The shift travels with the window so an in-flight window keeps its own kernel.
  always_comb begin
    rnd = '0;
`ifdef CONV3X3_ROUND_EN
    if (shift_s2_q != 4'd0) begin
      rnd = ACC_W'(1) << (shift_s2_q - 4'd1);
    end
`endif
    total_d = (ACC_W'(row_sum[0]) + ACC_W'(row_sum[1]) + ACC_W'(row_sum[2]) + rnd)
              >>> shift_s2_q;
  end

  always_comb begin
    if (total_q < 0) begin
      out_d = '0;
    end else if (total_q > PIX_MAX) begin
      out_d = '1;
    end else begin
      out_d = total_q[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      v4_q     <= 1'b0;
      out_q    <= '0;
      idx_q    <= '0;
      shadow_q <= identity_kernel();
      active_q <= identity_bank();
    end else begin
      v1_q     <= bus.i_valid;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      v4_q     <= v3_q;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      if (v3_q) begin
        out_q <= out_d;
      end
    end
    shift_s1_q <= active_q.shift;
    shift_s2_q <= shift_s1_q;
    total_q    <= total_d;
  end

  assign bus.o_valid      = v4_q;
  assign bus.o_data       = out_q;
  assign bus.o_coef_ready = (idx_q == '0);

endmodule
